// File: rtl/sort_pkg.sv
// Shared definitions for the sorting engines and the downstream result checker.
package sort_pkg;

  localparam int SORT_W = 32;
  localparam int SORT_N = 8;

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    STREAM,
    DONE
  } sort_chk_state_t;

  // Width of an element index; never narrower than one bit so N=1 still has a port.
  function automatic int sort_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sort_result_checker_if.sv
// Valid/ready stream of sorted elements leaving the result checker.
interface sort_result_checker_if
  import sort_pkg::*;
#(
  parameter int W  = SORT_W,
  parameter int IW = sort_idx_w(SORT_N)
) ();

  logic [W-1:0]  out_data;
  logic [IW-1:0] out_index;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;

  modport master (
    output out_data,
    output out_index,
    output out_valid,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_index,
    input  out_valid,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/sort_result_checker.sv
// Captures the bubble and insertion results, checks ordering and agreement one
// element per cycle, then streams the primary array out with sticky error flags.
module sort_result_checker
  import sort_pkg::*;
#(
  parameter int N = SORT_N,
  parameter int W = SORT_W,
  localparam int IW = sort_idx_w(N)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [N-1:0][W-1:0] array_a,
  input  logic [N-1:0][W-1:0] array_b,
  sort_result_checker_if.master out_if,
  output logic                busy,
  output logic                done,
  output logic                order_err,
  output logic                mismatch_err,
  output logic [IW-1:0]       first_err_idx
);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  sort_chk_state_t     state;
  sort_chk_state_t     state_nxt;

  logic [N-1:0][W-1:0] a_q;
  logic [N-1:0][W-1:0] b_q;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_inc;
  logic [IW-1:0]       idx_prev;

  logic                capture;
  logic                check_en;
  logic                stream_load;
  logic                advance;
  logic                finish;
  logic                mis_hit;
  logic                ord_hit;
  logic                xfer;

  assign idx_inc  = idx + 1'b1;
  assign idx_prev = idx - 1'b1;
  assign xfer     = out_if.out_valid && out_if.out_ready;

  // Element comparisons for the index currently under check; index 0 has no predecessor.
  assign mis_hit  = (a_q[idx] != b_q[idx]);
  assign ord_hit  = (idx != '0) && (a_q[idx] < a_q[idx_prev]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every clocked process uses non-blocking assignments so all registers
    // update together from pre-edge values, regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode and one-cycle datapath strobes.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_nxt   = state;
    capture     = 1'b0;
    check_en    = 1'b0;
    stream_load = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = CHECK;
        end
      end
      CHECK: begin
        check_en = 1'b1;
        if (idx == LAST_IDX) begin
          stream_load = 1'b1;
          state_nxt   = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (out_if.out_last) begin
            finish    = 1'b1;
            state_nxt = DONE;
          end else begin
            advance = 1'b1;
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Snapshot of both input arrays taken on an accepted start.
  always_ff @(posedge clk) begin
    // NOTE: the array copies carry no reset; they are always written on capture
    // before being read, so resetting them would only add wiring.
    if (capture) begin
      a_q <= array_a;
      b_q <= array_b;
    end
  end

  // Index counter, sticky error flags and registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx              <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      order_err        <= 1'b0;
      mismatch_err     <= 1'b0;
      first_err_idx    <= '0;
      out_if.out_data  <= '0;
      out_if.out_index <= '0;
      out_if.out_valid <= 1'b0;
      out_if.out_last  <= 1'b0;
    end else begin
      done <= finish;

      if (capture) begin
        idx           <= '0;
        busy          <= 1'b1;
        order_err     <= 1'b0;
        mismatch_err  <= 1'b0;
        first_err_idx <= '0;
      end

      if (check_en) begin
        if (mis_hit) mismatch_err <= 1'b1;
        if (ord_hit) order_err    <= 1'b1;
        // Only the first offending element is remembered.
        if ((mis_hit || ord_hit) && !mismatch_err && !order_err)
          first_err_idx <= idx;
        idx <= stream_load ? '0 : idx_inc;
      end

      if (stream_load) begin
        out_if.out_valid <= 1'b1;
        out_if.out_data  <= a_q[0];
        out_if.out_index <= '0;
        out_if.out_last  <= (N == 1);
      end

      if (advance) begin
        idx              <= idx_inc;
        out_if.out_data  <= a_q[idx_inc];
        out_if.out_index <= idx_inc;
        out_if.out_last  <= (idx_inc == LAST_IDX);
      end

      if (finish) begin
        busy             <= 1'b0;
        out_if.out_valid <= 1'b0;
        out_if.out_last  <= 1'b0;
      end
    end
  end

endmodule
